if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the 5-stage MIPS pipeline.
- Owns the PC and drives chip-enable and address to the combinational instruction ROM.
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles pipeline stall, flush/exception redirect, and branch redirect, including a branch that arrives during a stall.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_if  in  1  hold PC and the fetch stage (from pipeline control).
- stall_id  in  1  hold the decode stage (from pipeline control).
- flush  in  1  exception/eret flush; highest priority.
- new_pc  in  32  redirect target when flush=1.
- branch_flag_i  in  1  decode-stage branch/jump taken.
- branch_target_address_i  in  32  branch/jump target.
- rom_ce_o  out  1  ROM chip enable (ChipEnable/ChipDisable).
- rom_addr_o  out  32  ROM byte address; always equal to the PC register.
- rom_inst_i  in  32  ROM data, valid in the same cycle as rom_addr_o.
- id_pc_o  out  32  PC of the instruction held in IF/ID.
- id_inst_o  out  32  instruction held in IF/ID.
- id_valid_o  out  1  IF/ID holds a real instruction; 0 means bubble.
- if_adel_o  out  1  fetch address-error flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst=1) sets: state=IDLE, pc=RESET_PC, rom_ce_o=0, pending_valid=0, pending_pc=0, id_pc_o=0, id_inst_o=ZeroWord, id_valid_o=0, if_adel_o=0.
- IDLE: rom_ce_o=0. On the first edge after rst deasserts, go to RUN with PC unchanged, so the first fetch is at RESET_PC.
- RUN: rom_ce_o=1 and rom_addr_o=pc. Fetch latency is 0 cycles to the ROM and 1 cycle to IF/ID.
- RUN has no exit except rst; rst during RUN immediately returns to IDLE.
- Priority on each edge, highest first:
  1. flush: pc<=new_pc; IF/ID<=bubble (pc 0, inst ZeroWord, valid 0); pending_valid<=0.
  2. stall_if=1: PC held.
     - If branch_flag_i=1 and pending_valid=0: pending_pc<=branch_target_address_i, pending_valid<=1.
     - If stall_id=0: IF/ID<=bubble.
     - If stall_id=1: IF/ID held.
  3. pending_valid=1: pc<=pending_pc; pending_valid<=0; IF/ID<={pc, rom_inst_i, 1}.
  4. branch_flag_i=1: pc<=branch_target_address_i; IF/ID<={pc, rom_inst_i, 1}. The instruction captured here is the delay slot.
  5. Otherwise: pc<=pc+PC_INC; IF/ID<={pc, rom_inst_i, 1}.
- stall_id=1 with stall_if=0 is illegal (control never produces it). Treat it as stall_if=1.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- branch_flag_i during IDLE is ignored.
- flush during IDLE loads new_pc; the state still moves to RUN.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - In RUN, pc[1:0]!=0 is an address error. rom_ce_o is 0 that cycle.
  - The captured IF/ID entry is {pc, ZeroWord, valid 1}, with if_adel_o<=1 alongside it.
  - if_adel_o follows the IF/ID hold and bubble rules, and is cleared by flush.
  - The PC still advances by the normal priority rules.
- Not defined:
  - if_adel_o is tied to 0.
  - pc[1:0] is ignored; the ROM indexes by word.

Decomposition:
- Shared def.v supplies: InstAddrBus, InstBus, ZeroWord, ChipEnable, ChipDisable, RstEnable, and the new IF_STATE_IDLE/IF_STATE_RUN encodings (1-bit).
- One natural sub-module, if_pc_gen: state, PC register, pending-redirect register, and the priority mux.
- The top level keeps the IF/ID register and the optional alignment check.

Test Plan:
- Reset release: rst high for 3 cycles, then low. Cycle 1: ce=0, addr=0. Cycle 2: ce=1, addr=0. Then addr 4, 8, 12. id_pc_o lags addr by 1 cycle with valid=1.
- Branch at pc=0x10: branch_flag_i=1, target=0x100 for one cycle. id_pc_o shows 0x10 (delay slot). Next addr is 0x100.
- Branch during stall: stall_if=stall_id=1 for 2 cycles while branch_flag_i=1, target=0x200, at pc=0x20. PC holds 0x20 and IF/ID holds. After release: 0x20 is captured, then addr=0x200.
- Flush versus branch in the same cycle: flush=1, new_pc=0x180, branch_flag_i=1, target=0x40. Next addr=0x180, IF/ID is a bubble, and pending is cleared.
- Wrap: RESET_PC=32'hFFFF_FFF8 gives addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With FETCH_ALIGN_CHECK_EN: flush to new_pc=0x102. The next cycle has ce=0. Then id_inst_o=0, id_valid_o=1, if_adel_o=1, and the next addr is 0x106.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: bus widths, constant words, FSM and IF/ID encodings.
package if_fetch_unit_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;

  localparam logic [InstW-1:0] ZeroWord    = '0;
  localparam logic             ChipEnable  = 1'b1;
  localparam logic             ChipDisable = 1'b0;
  localparam logic             RstEnable   = 1'b1;

  typedef enum logic {
    IF_STATE_IDLE = 1'b0,
    IF_STATE_RUN  = 1'b1
  } if_state_e;

  // What the IF/ID register does on the next edge
  typedef enum logic [1:0] {
    IFID_HOLD    = 2'd0,
    IFID_BUBBLE  = 2'd1,
    IFID_CAPTURE = 2'd2
  } ifid_op_e;

  typedef struct packed {
    logic [InstAddrW-1:0] pc;
    logic [InstW-1:0]     inst;
    logic                 valid;
    logic                 adel;
  } ifid_t;

endpackage

// File: rtl/if_pc_gen.sv
// PC generator: fetch FSM, PC register, pending branch redirect and the redirect priority mux.
module if_pc_gen
  import if_fetch_unit_pkg::*;
#(
  parameter logic [InstAddrW-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned          PC_INC      = 4,
  parameter bit                   ALIGN_CHECK = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_if,
  input  logic                 stall_id,
  input  logic                 flush,
  input  logic [InstAddrW-1:0] new_pc,
  input  logic                 branch_flag_i,
  input  logic [InstAddrW-1:0] branch_target_address_i,
  output logic [InstAddrW-1:0] pc,
  output logic                 rom_ce,
  output logic                 addr_err_c,
  output ifid_op_e             ifid_op_c
);

  if_state_e            state, state_next;
  logic [InstAddrW-1:0] pc_next;
  logic                 pending_valid, pending_valid_next;
  logic [InstAddrW-1:0] pending_pc, pending_pc_next;

  // A misaligned PC in RUN is an address error only when the check is built in
  assign addr_err_c = ALIGN_CHECK && (state == IF_STATE_RUN) && (pc[1:0] != 2'b00);

  // State, PC, pending redirect and the registered ROM chip enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state         <= IF_STATE_IDLE;
      pc            <= RESET_PC;
      pending_valid <= 1'b0;
      pending_pc    <= '0;
      rom_ce        <= ChipDisable;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      pending_valid <= pending_valid_next;
      pending_pc    <= pending_pc_next;
      rom_ce        <= ((state_next == IF_STATE_RUN) &&
                        !(ALIGN_CHECK && (pc_next[1:0] != 2'b00))) ? ChipEnable : ChipDisable;
    end
  end

  // Next state and redirect priority: flush > stall > pending branch > branch > sequential
  always_comb begin
    state_next         = state;
    pc_next            = pc;
    pending_valid_next = pending_valid;
    pending_pc_next    = pending_pc;
    ifid_op_c          = IFID_HOLD;
    case (state)
      IF_STATE_IDLE: begin
        state_next = IF_STATE_RUN;
        if (flush) begin
          pc_next            = new_pc;
          pending_valid_next = 1'b0;
          ifid_op_c          = IFID_BUBBLE;
        end
      end
      IF_STATE_RUN: begin
        if (flush) begin
          pc_next            = new_pc;
          pending_valid_next = 1'b0;
          ifid_op_c          = IFID_BUBBLE;
        end else if (stall_if || stall_id) begin
          // stall_id without stall_if cannot occur; it is handled as a full stall
          if (branch_flag_i && !pending_valid) begin
            pending_pc_next    = branch_target_address_i;
            pending_valid_next = 1'b1;
          end
          ifid_op_c = stall_id ? IFID_HOLD : IFID_BUBBLE;
        end else if (pending_valid) begin
          pc_next            = pending_pc;
          pending_valid_next = 1'b0;
          ifid_op_c          = IFID_CAPTURE;
        end else if (branch_flag_i) begin
          pc_next   = branch_target_address_i;
          ifid_op_c = IFID_CAPTURE;
        end else begin
          pc_next   = pc + InstAddrW'(PC_INC);
          ifid_op_c = IFID_CAPTURE;
        end
      end
      default: state_next = IF_STATE_IDLE;
    endcase
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives the instruction ROM and fills the IF/ID register.
// Optional macro FETCH_ALIGN_CHECK_EN enables the fetch address-error check.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [InstAddrW-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned          PC_INC   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_if,
  input  logic                 stall_id,
  input  logic                 flush,
  input  logic [InstAddrW-1:0] new_pc,
  input  logic                 branch_flag_i,
  input  logic [InstAddrW-1:0] branch_target_address_i,
  output logic                 rom_ce_o,
  output logic [InstAddrW-1:0] rom_addr_o,
  input  logic [InstW-1:0]     rom_inst_i,
  output logic [InstAddrW-1:0] id_pc_o,
  output logic [InstW-1:0]     id_inst_o,
  output logic                 id_valid_o,
  output logic                 if_adel_o
);

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit AlignCheck = 1'b1;
`else
  localparam bit AlignCheck = 1'b0;
`endif

  logic [InstAddrW-1:0] pc;
  logic                 addr_err_c;
  ifid_op_e             ifid_op_c;
  ifid_t                ifid_q;
  ifid_t                capture_c;

  if_pc_gen #(
    .RESET_PC   (RESET_PC),
    .PC_INC     (PC_INC),
    .ALIGN_CHECK(AlignCheck)
  ) u_pc_gen (
    .clk                    (clk),
    .rst                    (rst),
    .stall_if               (stall_if),
    .stall_id               (stall_id),
    .flush                  (flush),
    .new_pc                 (new_pc),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .pc                     (pc),
    .rom_ce                 (rom_ce_o),
    .addr_err_c             (addr_err_c),
    .ifid_op_c              (ifid_op_c)
  );

  assign rom_addr_o = pc;

  // Entry captured this cycle; a faulting fetch carries a zero word and the error flag
  assign capture_c = '{pc:    pc,
                       inst:  addr_err_c ? ZeroWord : rom_inst_i,
                       valid: 1'b1,
                       adel:  addr_err_c};

  // IF/ID pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      ifid_q <= '0;
    end else begin
      case (ifid_op_c)
        IFID_BUBBLE:  ifid_q <= '0;
        IFID_CAPTURE: ifid_q <= capture_c;
        default:      ifid_q <= ifid_q;
      endcase
    end
  end

  assign id_pc_o    = ifid_q.pc;
  assign id_inst_o  = ifid_q.inst;
  assign id_valid_o = ifid_q.valid;
  assign if_adel_o  = ifid_q.adel;

endmodule
